bin_to_bcd_seq: RTL and testbench

- Sequential, parametrised binary-to-BCD converter using the iterative shift-and-add-3 (double-dabble) algorithm.
- Next generation of the team's fixed 8-bit combinational converter: generalised to any input width and digit count, with a start/busy/done handshake and overflow detection.
- Sits between the ALU result register and the 7-segment display drivers. It trades about WIDTH cycles of latency for a small, width-independent gate count.

---
 rtl/bin_to_bcd_seq_if.sv | 23 ++
 rtl/bin_to_bcd_seq.sv | 121 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
interface bin_to_bcd_seq_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;
  logic                  neg_out;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, overflow, neg_out
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, overflow, neg_out
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter with start/busy/done handshake.
// Optional two's-complement input when BIN_TO_BCD_SEQ_SIGNED_EN is defined.
module bin_to_bcd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  bin_to_bcd_seq_if.slave   bus
);
  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned RW = BW + WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_next;
  logic [RW-1:0]   work, work_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic            sticky, sticky_next;
  logic            neg, neg_next;
  logic            busy_q, busy_next;
  logic            done_q, done_next;
  logic [BW-1:0]   bcd_q, bcd_next;
  logic            ovf_q, ovf_next;
  logic            neg_q, neg_q_next;
  logic [BW-1:0]   adj;
  logic [WIDTH-1:0] load_mag;
  logic            load_neg;

  // Per-digit +3 correction, all digits in parallel.
  function automatic logic [BW-1:0] add3(input logic [BW-1:0] f);
    logic [BW-1:0] r;
    r = f;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (f[4*k +: 4] >= 4'd5) r[4*k +: 4] = f[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

`ifdef BIN_TO_BCD_SEQ_SIGNED_EN
  assign load_neg = bus.bin_in[WIDTH-1];
  assign load_mag = load_neg ? WIDTH'(-bus.bin_in) : bus.bin_in;
`else
  assign load_neg = 1'b0;
  assign load_mag = bus.bin_in;
`endif

  assign adj = add3(work[RW-1 -: BW]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      work   <= '0;
      cnt    <= '0;
      sticky <= 1'b0;
      neg    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      state  <= state_next;
      work   <= work_next;
      cnt    <= cnt_next;
      sticky <= sticky_next;
      neg    <= neg_next;
      busy_q <= busy_next;
      done_q <= done_next;
      bcd_q  <= bcd_next;
      ovf_q  <= ovf_next;
      neg_q  <= neg_q_next;
    end
  end

  always_comb begin
    state_next  = state;
    work_next   = work;
    cnt_next    = cnt;
    sticky_next = sticky;
    neg_next    = neg;
    done_next   = 1'b0;
    bcd_next    = bcd_q;
    ovf_next    = ovf_q;
    neg_q_next  = neg_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          work_next   = {BW'(0), load_mag};
          cnt_next    = CW'(WIDTH);
          sticky_next = 1'b0;
          neg_next    = load_neg;
          state_next  = SHIFT;
        end
      end
      SHIFT: begin
        // A set MSB on the corrected top digit is a carry past the last decimal place.
        work_next = {adj[BW-2:0], work[WIDTH-1:0], 1'b0};
        if (adj[BW-1]) sticky_next = 1'b1;
        cnt_next = cnt - CW'(1);
        if (cnt == CW'(1)) state_next = DONE;
      end
      DONE: begin
        bcd_next   = work[RW-1 -: BW];
        ovf_next   = sticky;
        neg_q_next = neg;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next == SHIFT);
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;
  assign bus.neg_out  = neg_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench: two converters (3 and 2 digits) driven in lockstep against an arithmetic model.
module tb_bin_to_bcd_seq;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.WIDTH(W), .DIGITS(3)) b3();
  bin_to_bcd_seq_if #(.WIDTH(W), .DIGITS(2)) b2();

  bin_to_bcd_seq #(.WIDTH(W), .DIGITS(3)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));
  bin_to_bcd_seq #(.WIDTH(W), .DIGITS(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic s, input logic [W-1:0] v);
    b3.start = s;  b2.start = s;
    b3.bin_in = v; b2.bin_in = v;
  endtask

  function automatic int unsigned mag(input logic [W-1:0] v);
`ifdef BIN_TO_BCD_SEQ_SIGNED_EN
    return v[W-1] ? (32'd256 - 32'(v)) : 32'(v);
`else
    return 32'(v);
`endif
  endfunction

  function automatic logic exp_neg(input logic [W-1:0] v);
`ifdef BIN_TO_BCD_SEQ_SIGNED_EN
    return v[W-1];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [39:0] ref_bcd(input int unsigned v, input int unsigned d);
    logic [39:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int k = 0; k < int'(d); k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int unsigned v, input int unsigned d);
    int unsigned lim;
    lim = 1;
    for (int k = 0; k < int'(d); k++) lim = lim * 10;
    return v >= lim;
  endfunction

  // One conversion; optionally re-assert start mid-conversion with another operand.
  task automatic run(input logic [W-1:0] v, input bit inject);
    int unsigned m;
    logic [39:0] e3, e2, got3, got2;
    logic o3, o2, n3;
    int busy_n, done_n, done_at, done2_n;
    m = mag(v);
    e3 = ref_bcd(m, 3);
    e2 = ref_bcd(m, 2);
    got3 = '0; got2 = '0; o3 = 1'b0; o2 = 1'b0; n3 = 1'b0;
    busy_n = 0; done_n = 0; done_at = 0; done2_n = 0;
    @(negedge clk); drive(1'b1, v);
    @(negedge clk); drive(1'b0, W'($urandom));
    for (int c = 1; c <= int'(W) + 5; c++) begin
      if (inject && c == 3) drive(1'b1, ~v);
      if (inject && c == 4) drive(1'b0, W'($urandom));
      if (b3.busy) busy_n++;
      if (b3.done) begin
        done_n++; done_at = c;
        got3 = 40'(b3.bcd_out); o3 = b3.overflow; n3 = b3.neg_out;
      end
      if (b2.done) begin
        done2_n++;
        got2 = 40'(b2.bcd_out); o2 = b2.overflow;
      end
      @(negedge clk);
    end
    check($sformatf("busy_cycles v=%0d", v), 40'(busy_n), 40'(W));
    check($sformatf("latency_clocks v=%0d", v), 40'(done_at - 1), 40'(W + 1));
    check($sformatf("done_pulses v=%0d", v), 40'(done_n), 40'd1);
    check($sformatf("done2_pulses v=%0d", v), 40'(done2_n), 40'd1);
    check($sformatf("bcd3 v=%0d", v), got3, e3);
    check($sformatf("ovf3 v=%0d", v), 40'(o3), 40'(ref_ovf(m, 3)));
    check($sformatf("neg3 v=%0d", v), 40'(n3), 40'(exp_neg(v)));
    check($sformatf("bcd2 v=%0d", v), got2, e2);
    check($sformatf("ovf2 v=%0d", v), 40'(o2), 40'(ref_ovf(m, 2)));
    check($sformatf("bcd3_hold v=%0d", v), 40'(b3.bcd_out), e3);
  endtask

  initial begin
    int d_idx [$];
    drive(1'b0, '0);
    repeat (2) @(negedge clk);
    check("reset_busy", 40'(b3.busy), 40'd0);
    check("reset_done", 40'(b3.done), 40'd0);
    check("reset_bcd", 40'(b3.bcd_out), 40'd0);
    check("reset_ovf", 40'(b3.overflow), 40'd0);
    check("reset_neg", 40'(b3.neg_out), 40'd0);
    rst = 1'b0;

    // Directed corner values.
    run(8'hFF, 1'b0);
    run(8'd199, 1'b0);
    run(8'd99, 1'b0);
    run(8'h80, 1'b0);
    run(8'h7F, 1'b0);
    run(8'd0, 1'b0);
    run(8'd100, 1'b0);

    // start re-asserted while busy is ignored.
    run(8'd173, 1'b1);
    run(8'd5, 1'b1);

    // Exhaustive sweep.
    for (int v = 0; v < 256; v++) run(8'(v), 1'b0);

    // Random operands, some with mid-conversion start noise.
    for (int i = 0; i < 30; i++) run(8'($urandom), bit'($urandom_range(0, 1)));

    // Reset with counter at 4 aborts the conversion.
    run(8'hFF, 1'b0);
    @(negedge clk); drive(1'b1, 8'd200);
    @(negedge clk); drive(1'b0, 8'd0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 40'(b3.busy), 40'd0);
    check("midrst_done", 40'(b3.done), 40'd0);
    check("midrst_bcd", 40'(b3.bcd_out), 40'd0);
    check("midrst_ovf", 40'(b3.overflow), 40'd0);
    check("midrst_bcd2", 40'(b2.bcd_out), 40'd0);
    @(negedge clk); rst = 1'b0;
    begin
      int dn;
      dn = 0;
      for (int c = 0; c < int'(W) + 4; c++) begin
        if (b3.done) dn++;
        @(negedge clk);
      end
      check("midrst_no_done", 40'(dn), 40'd0);
    end
    run(8'd42, 1'b0);
    check("after_rst_42", 40'(b3.bcd_out), 40'h042);

    // start held high: one conversion every W+2 cycles.
    @(negedge clk); drive(1'b1, 8'd137);
    for (int c = 1; c <= 3 * (int'(W) + 2) + 4; c++) begin
      @(negedge clk);
      if (b3.done) begin
        d_idx.push_back(c);
        check($sformatf("b2b_bcd%0d", d_idx.size()), 40'(b3.bcd_out), 40'h137);
      end
    end
    drive(1'b0, 8'd0);
    repeat (int'(W) + 4) @(negedge clk);
    check("b2b_done_count", 40'(d_idx.size()), 40'd3);
    if (d_idx.size() >= 3) begin
      check("b2b_period1", 40'(d_idx[1] - d_idx[0]), 40'(W + 2));
      check("b2b_period2", 40'(d_idx[2] - d_idx[1]), 40'(W + 2));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
